divider_unit: RTL and testbench
===============================

Name: divider_unit

Overview:
- Iterative radix-2 restoring divider, the inverse companion of the 16-bit Booth multiplier unit.
- Sits beside the ALU and executes DIV/DIVU/REM/REMU-style R-type ops on the low 16 bits of rs1 (read_a) and rs2 (read_x).
- Returns a 32-bit extended quotient or remainder.
- Multi-cycle with a start/busy/done handshake so the pipeline can stall on it.

Parameters:
- WIDTH, 16, operand width taken from the low bits of read_a/read_x; also the number of iteration cycles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = signed two's-complement divide, 0 = unsigned; latched at start
- op_rem  input  1  1 = return remainder, 0 = return quotient; latched at start
- read_a  input  32  dividend; only [WIDTH-1:0] used
- read_x  input  32  divisor; only [WIDTH-1:0] used
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when result is valid
- div_by_zero  output  1  registered with result; 1 if the latched divisor was 0
- result  output  32  quotient or remainder, extended to 32 bits

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; result=0, busy=0, done=0, div_by_zero=0; internal regs cleared.
  - Reset has priority over everything and aborts an in-flight op with no done pulse.
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE:
  - done is cleared at every edge spent in IDLE.
  - If start=1 at edge E0: latch is_signed, op_rem, sign bits, div_by_zero=(divisor==0).
  - Form magnitudes as WIDTH-bit unsigned abs values (signed mode only); -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow.
  - Clear partial remainder (WIDTH+1 bits) and iteration count; busy=1; go to ITER.
- ITER, one bit per edge, MSB first, for exactly WIDTH edges:
  - Shift {rem, dividend} left one bit.
  - Trial subtract divisor magnitude. If non-negative, keep the difference and set quotient bit=1; otherwise restore and set the bit to 0.
  - After the WIDTH-th iteration, go to FIX.
- FIX (one edge), signed mode:
  - Negate the quotient if dividend sign != divisor sign.
  - Negate the remainder if the dividend is negative.
  - Remainder sign always follows the dividend.
- Divide by zero (overrides FIX): quotient = all ones (WIDTH bits), remainder = original dividend.
- Signed overflow (-2^(WIDTH-1) / -1): falls out naturally as quotient = -2^(WIDTH-1), remainder = 0. No special case.
- Extension and completion:
  - Select quotient or remainder per op_rem.
  - Extend to 32 bits: sign-extend if is_signed, else zero-extend.
  - Write result, set done=1, busy=0, go to IDLE.
- Latency: start sampled at E0, done high after edge E0+WIDTH+1 (17 cycles for WIDTH=16). Latency is fixed, including divide by zero.
- result and div_by_zero hold until the next completion or reset.
- start while busy: ignored, with no queuing.
- start on the cycle done is high: accepted, since the block is back in IDLE.
- Upper operand bits [31:WIDTH] never affect the result.
- Operand inputs are only sampled at the accepting edge. Changes during busy have no effect.

Test Plan:
- Signed 100/7: is_signed=1, read_a=0x00000064, read_x=0x00000007 -> quotient 0x0000000E, remainder 0x00000002; done exactly 17 cycles after start.
- Signed negative: -100/7 (read_a=0x0000FF9C) -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE.
- Signed 100/-7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
- Unsigned: read_a=0xABCDFFFF, read_x=0x00000002, is_signed=0 -> quotient 0x00007FFF, remainder 0x00000001. Upper bits are ignored.
- Divide by zero: 0x04D2/0, signed -> quotient 0xFFFFFFFF, remainder 0x000004D2, div_by_zero=1. Unsigned -> quotient 0x0000FFFF.
- Overflow: read_a=0x8000, read_x=0xFFFF, signed -> quotient 0xFFFF8000, remainder 0x00000000, div_by_zero=0.
- Control:
  - Pulse start again while busy with different operands -> ignored; the first result is returned at the original time.
  - Assert reset=0 at iteration 5 -> busy=0, done never pulses, result=0.
  - A fresh start after reset completes correctly.

Source files
------------

// File: rtl/divider_unit.sv
// rtl/divider_unit.sv - iterative radix-2 restoring divider, signed/unsigned, quotient or remainder
module divider_unit #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic        op_rem,
    input  logic [31:0] read_a,
    input  logic [31:0] read_x,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_signed;
    logic             r_op_rem;
    logic             r_neg_a;
    logic             r_neg_x;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_orig_a;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_x;
    logic             w_neg_a;
    logic             w_neg_x;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_x;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rmd;
    logic [WIDTH-1:0] w_sel;
    logic [31:0]      w_ext;
    logic             w_unused_hi;

    assign w_a         = read_a[WIDTH-1:0];
    assign w_x         = read_x[WIDTH-1:0];
    assign w_unused_hi = ^{read_a[31:WIDTH], read_x[31:WIDTH]};
    assign w_neg_a     = is_signed & w_a[WIDTH-1];
    assign w_neg_x     = is_signed & w_x[WIDTH-1];
    // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_mag_a     = w_neg_a ? -w_a : w_a;
    assign w_mag_x     = w_neg_x ? -w_x : w_x;

    assign w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_qbit  = ~w_diff[WIDTH];

    always_comb begin
        w_quo = r_dvd;
        w_rmd = r_rem[WIDTH-1:0];
        if (div_by_zero) begin
            w_quo = '1;
            w_rmd = r_orig_a;
        end else if (r_signed) begin
            if (r_neg_a ^ r_neg_x) w_quo = -r_dvd;
            if (r_neg_a)           w_rmd = -r_rem[WIDTH-1:0];
        end
        w_sel = r_op_rem ? w_rmd : w_quo;
        w_ext = r_signed ? {{(32-WIDTH){w_sel[WIDTH-1]}}, w_sel}
                         : {{(32-WIDTH){1'b0}}, w_sel};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_signed    <= 1'b0;
            r_op_rem    <= 1'b0;
            r_neg_a     <= 1'b0;
            r_neg_x     <= 1'b0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_orig_a    <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_signed    <= is_signed;
                        r_op_rem    <= op_rem;
                        r_neg_a     <= w_neg_a;
                        r_neg_x     <= w_neg_x;
                        r_dvd       <= w_mag_a;
                        r_dvs       <= w_mag_x;
                        r_orig_a    <= w_a;
                        r_rem       <= '0;
                        r_cnt       <= '0;
                        div_by_zero <= (w_x == '0);
                        busy        <= 1'b1;
                        r_state     <= ITER;
                    end
                end
                ITER: begin
                    // Quotient bits shift into the dividend register as dividend bits shift out.
                    r_rem   <= w_qbit ? w_diff : w_shift;
                    r_dvd   <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
                end
                FIX: begin
                    result  <= w_ext;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// tb/tb_divider_unit.sv - randomized self-checking bench for divider_unit against an arithmetic model
module tb_divider_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic        op_rem;
    logic [31:0] read_a;
    logic [31:0] read_x;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int done_seen;

    divider_unit #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .op_rem      (op_rem),
        .read_a      (read_a),
        .read_x      (read_x),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input bit sg, input bit rm,
                                            input logic [31:0] a, input logic [31:0] x);
        logic [15:0] a16;
        logic [15:0] x16;
        logic [15:0] sel;
        int          sa;
        int          sx;
        int          q;
        int          r;
        a16 = a[15:0];
        x16 = x[15:0];
        sa  = sg ? int'($signed(a16)) : int'({16'h0, a16});
        sx  = sg ? int'($signed(x16)) : int'({16'h0, x16});
        if (sx == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sx;
            r = sa % sx;
        end
        sel = rm ? r[15:0] : q[15:0];
        return sg ? {{16{sel[15]}}, sel} : {16'h0, sel};
    endfunction

    task automatic run_op(input string tag, input bit sg, input bit rm,
                          input logic [31:0] a, input logic [31:0] x, input bit poke);
        int n;
        logic [31:0] exp;
        exp = ref_div(sg, rm, a, x);
        @(negedge clk);
        start = 1'b1; is_signed = sg; op_rem = rm; read_a = a; read_x = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        read_a = $urandom; read_x = $urandom; is_signed = ~sg; op_rem = ~rm;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            if (poke && n == 3) start = 1'b1;
            if (poke && n == 4) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, 32'd17);
        check({tag, "_res"}, result, exp);
        check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, (x[15:0] == 16'h0)});
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; is_signed = 1'b0; op_rem = 1'b0;
        read_a = '0; read_x = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'b0, busy, done, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("s100_7_q", 1, 0, 32'h0000_0064, 32'h0000_0007, 0);
        check("s100_7_q_const", result, 32'h0000_000E);
        @(posedge clk); #1;
        check("done_pulse", {31'b0, done}, 32'd0);
        run_op("s100_7_r", 1, 1, 32'h0000_0064, 32'h0000_0007, 0);
        check("s100_7_r_const", result, 32'h0000_0002);
        run_op("sn100_7_q", 1, 0, 32'h0000_FF9C, 32'h0000_0007, 0);
        check("sn100_7_q_const", result, 32'hFFFF_FFF2);
        run_op("sn100_7_r", 1, 1, 32'h0000_FF9C, 32'h0000_0007, 0);
        check("sn100_7_r_const", result, 32'hFFFF_FFFE);
        run_op("s100_n7_q", 1, 0, 32'h0000_0064, 32'h0000_FFF9, 0);
        check("s100_n7_q_const", result, 32'hFFFF_FFF2);
        run_op("s100_n7_r", 1, 1, 32'h0000_0064, 32'h0000_FFF9, 0);
        check("s100_n7_r_const", result, 32'h0000_0002);
        run_op("u_hi_q", 0, 0, 32'hABCD_FFFF, 32'h0000_0002, 0);
        check("u_hi_q_const", result, 32'h0000_7FFF);
        run_op("u_hi_r", 0, 1, 32'hABCD_FFFF, 32'h0000_0002, 0);
        check("u_hi_r_const", result, 32'h0000_0001);
        run_op("dbz_s_q", 1, 0, 32'h0000_04D2, 32'h0000_0000, 0);
        check("dbz_s_q_const", result, 32'hFFFF_FFFF);
        run_op("dbz_s_r", 1, 1, 32'h0000_04D2, 32'h0000_0000, 0);
        check("dbz_s_r_const", result, 32'h0000_04D2);
        run_op("dbz_u_q", 0, 0, 32'h0000_04D2, 32'h0000_0000, 0);
        check("dbz_u_q_const", result, 32'h0000_FFFF);
        run_op("ovf_q", 1, 0, 32'h0000_8000, 32'h0000_FFFF, 0);
        check("ovf_q_const", result, 32'hFFFF_8000);
        run_op("ovf_r", 1, 1, 32'h0000_8000, 32'h0000_FFFF, 0);
        check("ovf_r_const", result, 32'h0000_0000);
        run_op("poke", 0, 0, 32'h0000_1234, 32'h0000_0011, 1);

        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op_rem = 1'b0; read_a = 32'h0000_9999; read_x = 32'h3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        run_op("after_rst", 1, 1, 32'h0000_FF9C, 32'h0000_0007, 0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [31:0] x;
            a = $urandom;
            x = $urandom;
            case ($urandom_range(0, 5))
                0: x[15:0] = 16'h0000;
                1: a[15:0] = 16'h8000;
                2: x[15:0] = 16'hFFFF;
                3: x[15:0] = 16'(1 + $urandom_range(0, 15));
                default: ;
            endcase
            run_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, x, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
